// File: rtl/systolic_job_sequencer_if.sv
// Handshake and array-edge bundle for systolic_job_sequencer.
// master: the sequencer side. slave: the load source, the result consumer and the array.
interface systolic_job_sequencer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] arr_in1;
  logic [7:0] arr_in2;
  logic       arr_readout;
  logic [7:0] arr_res;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  modport master (
    input  s_data, s_valid, arr_res, m_ready,
    output s_ready, arr_in1, arr_in2, arr_readout, m_data, m_valid, busy, done
  );

  modport slave (
    output s_data, s_valid, arr_res, m_ready,
    input  s_ready, arr_in1, arr_in2, arr_readout, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/systolic_job_sequencer.sv
// Sequences one 8x8 boolean matrix product C = A.B through the systolic array:
// loads A and B as a byte stream, feeds skewed operands into the array edges,
// drains, reads the result rows back out and streams C to the consumer.
// Optional feature macro: SYSSEQ_REUSE_B_EN adds the reuse_b port, which lets a
// job load only A and keep the previous job's B.
module systolic_job_sequencer #(
  parameter int DRAIN_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef SYSSEQ_REUSE_B_EN
  input  logic reuse_b,
`endif
  systolic_job_sequencer_if.master bus
);

  // The phase counter must reach 16 in READ and DRAIN_CYCLES-1 in DRAIN.
  localparam int CNT_W = (DRAIN_CYCLES > 32) ? $clog2(DRAIN_CYCLES) : 5;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_EMIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       ld_cnt, ld_cnt_nxt;
  logic [2:0]       em_cnt, em_cnt_nxt;

  logic [7:0] abuf [8];
  logic [7:0] bbuf [8];
  logic [7:0] cbuf [8];

  logic [7:0] feed_top, feed_left;
  logic [7:0] top_p0, left_p0;
  logic       rd_p0;
  logic       done_p0;

  logic       reuse_job;
  logic       s_fire;
  logic       last_beat;
  logic       cap_en;
  logic [2:0] cap_idx;

  assign s_fire    = (state == S_LOAD) && bus.s_valid;
  assign last_beat = (ld_cnt == 4'd15) || ((ld_cnt == 4'd7) && reuse_job);

  // READ runs 17 state cycles because the readout flag is registered: state
  // cycle c observes the array in readout shift r = c-1, so odd r lands on
  // even c >= 2 and row (15-r)/2 = (16-c)/2 is captured at the end of it.
  assign cap_en  = (state == S_READ) && (cnt != '0) && !cnt[0];
  assign cap_idx = 3'((5'd16 - 5'(cnt)) >> 1);

  // Next-state and counter decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ld_cnt_nxt = ld_cnt;
    em_cnt_nxt = em_cnt;
    unique case (state)
      S_LOAD: begin
        if (bus.s_valid) begin
          if (last_beat) begin
            ld_cnt_nxt = '0;
            cnt_nxt    = '0;
            state_nxt  = S_FEED;
          end else begin
            ld_cnt_nxt = ld_cnt + 4'd1;
          end
        end
      end
      S_FEED: begin
        if (cnt == CNT_W'(14)) begin
          cnt_nxt   = '0;
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_READ;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_READ: begin
        if (cnt == CNT_W'(16)) begin
          cnt_nxt   = '0;
          state_nxt = S_EMIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.m_ready) begin
          em_cnt_nxt = em_cnt + 3'd1;
          if (em_cnt == 3'd7) begin
            state_nxt = S_LOAD;
          end
        end
      end
      default: begin
        state_nxt = S_LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Skewed operand decode: row i of A is delayed by i cycles, column j of B by j
  always_comb begin
    feed_top  = '0;
    feed_left = '0;
    for (int j = 0; j < 8; j++) begin
      if ((int'(cnt) >= j) && (int'(cnt) - j <= 7)) begin
        feed_top[j] = bbuf[3'(int'(cnt) - j)][j];
      end
    end
    for (int i = 0; i < 8; i++) begin
      if ((int'(cnt) >= i) && (int'(cnt) - i <= 7)) begin
        feed_left[i] = abuf[i][3'(int'(cnt) - i)];
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_LOAD;
      cnt    <= '0;
      ld_cnt <= '0;
      em_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ld_cnt <= ld_cnt_nxt;
      em_cnt <= em_cnt_nxt;
    end
  end

  // Registered array edge drive and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_p0  <= '0;
      left_p0 <= '0;
      rd_p0   <= 1'b0;
      done_p0 <= 1'b0;
    end else begin
      top_p0  <= (state == S_FEED) ? feed_top  : 8'h00;
      left_p0 <= (state == S_FEED) ? feed_left : 8'h00;
      rd_p0   <= (state == S_READ) && (cnt != CNT_W'(16));
      done_p0 <= (state == S_EMIT) && bus.m_ready && (em_cnt == 3'd7);
    end
  end

  // A operand buffer and result row capture
  always_ff @(posedge clk) begin
    if (s_fire && !ld_cnt[3]) begin
      abuf[ld_cnt[2:0]] <= bus.s_data;
    end
    if (cap_en) begin
      cbuf[cap_idx] <= bus.arr_res;
    end
  end

`ifdef SYSSEQ_REUSE_B_EN
  // B operand buffer; cleared by reset so a reused B after reset is all zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        bbuf[k] <= 8'h00;
      end
    end else if (s_fire && ld_cnt[3]) begin
      bbuf[ld_cnt[2:0]] <= bus.s_data;
    end
  end

  // Reuse request, taken with load beat 0 and held for the rest of the load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reuse_job <= 1'b0;
    end else if (s_fire && (ld_cnt == 4'd0)) begin
      reuse_job <= reuse_b;
    end
  end
`else
  // B operand buffer
  always_ff @(posedge clk) begin
    if (s_fire && ld_cnt[3]) begin
      bbuf[ld_cnt[2:0]] <= bus.s_data;
    end
  end

  assign reuse_job = 1'b0;
`endif

  assign bus.s_ready     = (state == S_LOAD);
  assign bus.m_valid     = (state == S_EMIT);
  assign bus.m_data      = (state == S_EMIT) ? cbuf[em_cnt] : 8'h00;
  assign bus.busy        = !((state == S_LOAD) && (ld_cnt == 4'd0));
  assign bus.done        = done_p0;
  assign bus.arr_in1     = top_p0;
  assign bus.arr_in2     = left_p0;
  assign bus.arr_readout = rd_p0;

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Bench for systolic_job_sequencer. Plays the load source, the result consumer
// and the systolic array's row-7 output: during each readout shift it presents
// the reference product row the array would shift out at that point.
module tb_systolic_job_sequencer;

  localparam int D   = 16;
  localparam int LAT = 32 + D;

  logic clk;
  logic reset;
`ifdef SYSSEQ_REUSE_B_EN
  logic reuse_b;
`endif

  systolic_job_sequencer_if bus ();

  systolic_job_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef SYSSEQ_REUSE_B_EN
    .reuse_b(reuse_b),
`endif
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [7:0] A [8];
  logic [7:0] B [8];
  logic [7:0] Beff [8];
  logic [7:0] lastB [8];
  logic [7:0] C [8];

  // Boolean matrix product from the definition
  task automatic compute_c();
    for (int i = 0; i < 8; i++) begin
      C[i] = 8'h00;
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 8; k++)
          if (A[i][k] && Beff[k][j]) C[i][j] = 1'b1;
    end
  endtask

  // Top edge at feed step t: column j carries B[t-j][j]
  function automatic logic [7:0] exp_top(input int t);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 0; j < 8; j++)
      if (t - j >= 0 && t - j <= 7) v[j] = Beff[t - j][j];
    return v;
  endfunction

  // Left edge at feed step t: row i carries A[i][t-i]
  function automatic logic [7:0] exp_left(input int t);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++)
      if (t - i >= 0 && t - i <= 7) v[i] = A[i][t - i];
    return v;
  endfunction

  task automatic clear_b_history();
    for (int k = 0; k < 8; k++) lastB[k] = 8'h00;
  endtask

  // One complete job: load, watch the array edges cycle by cycle, drain results.
  // mode 0: m_ready held high, 1: m_ready pattern 1-0-0-1, 2: random m_ready
  task automatic run_job(input bit reuse, input int mode, input string tag);
    int nbeats;
    int e;
    int k;
    int r;
    nbeats = reuse ? 8 : 16;
    for (int q = 0; q < 8; q++) begin
      Beff[q] = reuse ? lastB[q] : B[q];
    end
    compute_c();
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      bus.s_data  = (b < 8) ? A[b] : B[b - 8];
      bus.s_valid = 1'b1;
`ifdef SYSSEQ_REUSE_B_EN
      reuse_b = (b == 0) ? reuse : 1'($urandom);
`endif
      @(posedge clk);
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
    for (int q = 0; q < 8; q++) lastB[q] = Beff[q];

    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk);
      #1;
      r = n - (16 + D);
      if (r >= 0 && r < 16 && r % 2 == 1) bus.arr_res = C[(15 - r) / 2];
      else bus.arr_res = 8'($urandom);
      if (n == 1) begin
        n_checks++;
        if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy/s_ready after load: busy=%b s_ready=%b, want 1/0", tag, bus.busy, bus.s_ready);
        end
      end
      if (n <= 15) begin
        n_checks++;
        if (bus.arr_in1 !== exp_top(n - 1) || bus.arr_in2 !== exp_left(n - 1) || bus.arr_readout !== 1'b0) begin
          n_fail++;
          $display("FAIL %s feed t=%0d: in1=%h in2=%h rd=%b, want %h %h 0", tag, n - 1,
                   bus.arr_in1, bus.arr_in2, bus.arr_readout, exp_top(n - 1), exp_left(n - 1));
        end
      end else begin
        n_checks++;
        if (bus.arr_in1 !== 8'h00 || bus.arr_in2 !== 8'h00 ||
            bus.arr_readout !== ((r >= 0 && r < 16) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL %s edge cycle %0d: in1=%h in2=%h rd=%b, want 00 00 %b", tag, n,
                   bus.arr_in1, bus.arr_in2, bus.arr_readout, (r >= 0 && r < 16));
        end
      end
      n_checks++;
      if (bus.m_valid !== (n == LAT)) begin
        n_fail++;
        $display("FAIL %s m_valid at cycle %0d after last load beat: got %b want %b", tag, n, bus.m_valid, (n == LAT));
      end
    end

    e = 0;
    k = 0;
    while (e < 8 && k < 64) begin
      case (mode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: bus.m_ready = 1'($urandom);
      endcase
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== C[e]) begin
        n_fail++;
        $display("FAIL %s result row %0d: m_valid=%b m_data=%h, want 1 %h", tag, e, bus.m_valid, bus.m_data, C[e]);
      end
      @(posedge clk);
      #1;
      if (bus.m_ready) e++;
      k++;
    end
    if (e < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s emit timeout: %0d rows accepted, want 8", tag, e);
    end
    bus.m_ready = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s completion: done=%b s_ready=%b m_valid=%b busy=%b, want 1 1 0 0", tag,
               bus.done, bus.s_ready, bus.m_valid, bus.busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done pulse width: done=%b one cycle later, want 0", tag, bus.done);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m_valid !== 1'b0 ||
        bus.m_data !== 8'h00 || bus.arr_in1 !== 8'h00 || bus.arr_in2 !== 8'h00 || bus.arr_readout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: s_ready=%b busy=%b done=%b m_valid=%b m_data=%h in1=%h in2=%h rd=%b, want 1 0 0 0 00 00 00 0",
               tag, bus.s_ready, bus.busy, bus.done, bus.m_valid, bus.m_data, bus.arr_in1, bus.arr_in2, bus.arr_readout);
    end
  endtask

  task automatic set_identity_a();
    for (int i = 0; i < 8; i++) A[i] = 8'(1 << i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk);
    reset = 1'b0;
    clear_b_history();
    #1;
    check_reset_values("after_reset_release");
  endtask

  task automatic test_identity();
    logic [7:0] brows [8];
    brows = '{8'h5A, 8'h3C, 8'hA5, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    set_identity_a();
    for (int i = 0; i < 8; i++) B[i] = brows[i];
    run_job(1'b0, 0, "identity");
  endtask

  task automatic test_zero();
    for (int i = 0; i < 8; i++) begin
      A[i] = 8'h00;
      B[i] = 8'h00;
    end
    run_job(1'b0, 0, "zero");
  endtask

  task automatic test_single_term();
    for (int i = 0; i < 8; i++) begin
      A[i] = 8'h00;
      B[i] = 8'h00;
    end
    A[2] = 8'h20;
    B[5] = 8'h40;
    run_job(1'b0, 0, "single_term");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      A[i] = 8'hFF;
      B[i] = 8'hFF;
    end
    run_job(1'b0, 0, "b2b_ones");
    set_identity_a();
    for (int i = 0; i < 8; i++) B[i] = 8'h00;
    run_job(1'b0, 0, "b2b_identity_zero");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) begin
      A[i] = 8'($urandom);
      B[i] = 8'($urandom);
    end
    run_job(1'b0, 1, "stall_1001");
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 8; i++) begin
        A[i] = 8'($urandom);
        B[i] = 8'($urandom);
      end
      run_job(1'b0, 2, "random");
    end
  endtask

  task automatic test_reset_mid();
    // abandon a partial load
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      bus.s_data  = 8'($urandom);
      bus.s_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_load");
    @(negedge clk);
    reset = 1'b0;
    clear_b_history();
    // full load, then reset a few cycles into FEED
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus.s_data  = 8'($urandom);
      bus.s_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    bus.s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_feed");
    @(negedge clk);
    reset = 1'b0;
    clear_b_history();
    set_identity_a();
    for (int i = 0; i < 8; i++) B[i] = 8'($urandom);
    run_job(1'b0, 0, "after_reset_identity");
  endtask

`ifdef SYSSEQ_REUSE_B_EN
  task automatic test_reuse_b();
    for (int i = 0; i < 8; i++) A[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) B[i] = 8'($urandom);
    run_job(1'b1, 0, "reuse_b");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.s_data   = 8'h00;
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b0;
    bus.arr_res  = 8'h00;
`ifdef SYSSEQ_REUSE_B_EN
    reuse_b      = 1'b0;
`endif
    clear_b_history();
    test_reset();
    test_identity();
    test_zero();
    test_single_term();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef SYSSEQ_REUSE_B_EN
    test_reuse_b();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_job_sequencer.md
# systolic_job_sequencer

Sequences one boolean matrix product C = A·B (OR of ANDs, 8x8 bits) through the 8x8 systolic_cell array. The block accepts A and B as a byte stream, drives the array's top and left edges with correctly skewed operands, drains the pipeline, and asserts the array readout. It then captures the shifted-out result rows and returns C as a byte stream. It replaces the free-running alternating input capture in the top-level processor, and it is the only driver of the array edge ports.

## Interface
- DRAIN_CYCLES, 16: number of zero-feed cycles between FEED and READ; legal values are 16 or more.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  8  load byte. Beats 0-7 are A row i, with bit k = A[i][k]. Beats 8-15 are B row k, with bit j = B[k][j].
- s_valid  in  1  load byte valid.
- s_ready  out  1  block accepts a load byte.
- arr_in1  out  8  array top edge (column j is bit j). Registered.
- arr_in2  out  8  array left edge (row i is bit i). Registered.
- arr_readout  out  1  array readout mode. Registered.
- arr_res  in  8  out1 bus of array row 7.
- m_data  out  8  result row C[r], with bit j = C[r][j].
- m_valid  out  1  result byte valid.
- m_ready  in  1  consumer accepts a result byte.
- busy  out  1  high in every state except LOAD with zero beats taken.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- The state machine has five states: LOAD, FEED, DRAIN, READ, EMIT. It uses one 5-bit phase counter `cnt`, plus separate byte counters for load and emit.
- LOAD
  - s_ready = 1.
  - Each s_valid&s_ready beat writes the next byte into abuf[0..7] and then bbuf[0..7].
  - After beat 15, go to FEED with cnt = 0.
- FEED: 15 cycles, t = cnt = 0..14.
  - arr_in1[j] = B[t-j][j] when 0 ≤ t-j ≤ 7, else 0.
  - arr_in2[i] = A[i][t-i] when 0 ≤ t-i ≤ 7, else 0.
  - arr_readout = 0.
  - Purpose: cell (i,j) sees A[i][k] and B[k][j] in the same cycle for every k.
- DRAIN: DRAIN_CYCLES cycles with arr_in1 = arr_in2 = 0 and arr_readout = 0.
- READ: 16 cycles, r = 0..15.
  - arr_readout = 1, arr_in1 = arr_in2 = 0.
  - At the end of READ cycle r, for odd r, capture arr_res into cbuf[(15-r)/2]. So r=1 captures C[7] and r=15 captures C[0]. Even-r samples are discarded.
  - The 16 readout shifts also load zeros into every accumulator, so no clear is needed between jobs.
- EMIT
  - m_valid = 1, m_data = cbuf[e] for e = 0..7.
  - e advances on m_valid&m_ready.
  - After e = 7 is accepted: done pulses, state returns to LOAD, buffers are retained.
- s_ready = 0 in every state other than LOAD. m_valid = 0 in every state other than EMIT.
- Reset mid-operation (any state) forces the reset values below. A partially loaded job is discarded.

## Timing
- Reset values:
  - state = LOAD, all counters 0, busy = 0, done = 0, m_valid = 0.
  - arr_in1 = arr_in2 = 0, arr_readout = 0, m_data = 0.
  - s_ready = 1, since it is decoded from state.
- Latency:
  - Call the edge that accepts load beat 15 E0.
  - FEED occupies cycles 1..15 after E0.
  - DRAIN occupies cycles 16..15+DRAIN_CYCLES.
  - READ occupies the next 16 cycles.
  - m_valid first asserts 32+DRAIN_CYCLES cycles after E0 (48 at the default).
- EMIT holds m_data and m_valid stable while m_ready = 0.
- Throughput:
  - One byte per cycle in LOAD and in EMIT when valid/ready stay high.
  - s_ready rises in the cycle after the final result handshake.
- Simultaneous events: the done pulse and s_ready = 1 occur in the same cycle. A load beat accepted in that cycle counts as beat 0 of the next job.

## Configuration
- SYSSEQ_REUSE_B_EN
  - Defined: adds input port reuse_b (1 bit). It is sampled with load beat 0. If reuse_b = 1, LOAD ends after beat 7 (A only) and bbuf keeps the previous job's B. After reset, bbuf = 0.
  - Undefined: the port is absent and every job loads 16 beats.

## Test plan
- Identity A (rows 0x01, 0x02, 0x04, … 0x80) with B rows 0x5A, 0x3C, … → C rows equal the B rows, first m_valid 48 cycles after E0.
- A = B = all 0x00 → eight result bytes 0x00, then done pulses once.
- A[2] = 0x20, B[5] = 0x40, all other rows 0 → C[2] = 0x40, all other rows 0x00.
- Two back-to-back jobs, all-ones then identity × 0x00 → second job returns all 0x00 (proves no residual accumulator state).
- m_ready toggled 1-0-0-1 throughout EMIT → m_data held stable while stalled, all 8 bytes in order, no drops or duplicates.
- Reset asserted mid-FEED, then a full identity × B job → correct C. With SYSSEQ_REUSE_B_EN defined, an 8-beat job with reuse_b = 1 returns results using the prior B.
